word_serializer: RTL

- Parallel-in, serial-out converter: the unpacking counterpart of the word-wide delay/shift line.
- Accepts one block of shift_depth words, each d_width bits, in a single handshake.
- Emits the block one word per cycle on a valid/ready stream, oldest word (index 0) first.
- Feeds word-serial datapaths downstream of blocks that produce packed parallel results.

---
 rtl/word_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : word_serializer
//  Purpose  : Parallel-in, serial-out converter. Accepts one packed block of
//             SHIFT_DEPTH words (D_WIDTH bits each) in a single handshake and
//             emits it one word per cycle on a valid/ready stream, word 0
//             first. A new block may be accepted in the cycle the last word
//             of the current block transfers, giving bubble-free throughput.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous active-high reset
//             load_valid - load_data holds a valid block
//             load_ready - serializer can accept a block this cycle
//             load_data  - packed block, word i at [i*D_WIDTH +: D_WIDTH]
//             out_valid  - out_data holds a valid word
//             out_ready  - downstream accepts out_data this cycle
//             out_data   - current serial word
//             out_last   - current word is the final word of the block
//  Revision : 1.0 - initial release
// ============================================================================
module word_serializer #(
    parameter int D_WIDTH     = 4,
    parameter int SHIFT_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [D_WIDTH*SHIFT_DEPTH-1:0] load_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [D_WIDTH-1:0]             out_data,
    output logic                           out_last
);

    localparam int BLOCK_W = D_WIDTH * SHIFT_DEPTH;
    localparam int CNT_W   = (SHIFT_DEPTH > 1) ? $clog2(SHIFT_DEPTH) : 1;

    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(SHIFT_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [BLOCK_W-1:0] r_block;

    logic               w_accept;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_count_inc;
    logic [BLOCK_W-1:0] w_shifted;

    // In SHIFT a new block can only enter as the last word leaves; this path
    // is combinational from out_ready so back-to-back blocks have no gap.
    assign load_ready  = (r_state == S_IDLE) || (out_last && out_ready);
    assign w_accept    = load_valid && load_ready;
    assign w_xfer      = out_valid && out_ready;
    assign w_count_inc = r_count + 1'b1;

    // The block register is consumed by shifting, so the next word is always
    // in the low bits; this avoids a variable-index mux on the block.
    assign w_shifted   = r_block >> D_WIDTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_block   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_block   <= load_data;
                        r_count   <= '0;
                        out_valid <= 1'b1;
                        out_data  <= load_data[D_WIDTH-1:0];
                        out_last  <= (SHIFT_DEPTH == 1);
                        r_state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_accept) begin
                        // Last word transferring and a new block waiting.
                        r_block   <= load_data;
                        r_count   <= '0;
                        out_valid <= 1'b1;
                        out_data  <= load_data[D_WIDTH-1:0];
                        out_last  <= (SHIFT_DEPTH == 1);
                    end else if (w_xfer) begin
                        if (!out_last) begin
                            r_count  <= w_count_inc;
                            r_block  <= w_shifted;
                            out_data <= w_shifted[D_WIDTH-1:0];
                            out_last <= (w_count_inc == c_last_count);
                        end else begin
                            r_state   <= S_IDLE;
                            r_count   <= '0;
                            r_block   <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
